seq_divider_8: RTL and testbench

- Multi-cycle unsigned restoring divider, WIDTH-bit dividend / WIDTH-bit divisor, one quotient bit per clock.
- Sits directly upstream of the team's 8-bit ripple-carry subtractor (A - B with borrow-in).
- Drives the subtractor's A/B/borrow-in each cycle, consumes its difference and carry/borrow output, and accepts or restores the partial remainder.
- Provides the datapath's divide operation with a start/busy/done handshake.

---
 rtl/seq_divider_8.sv | 111 +++++++++++
 tb/tb_seq_divider_8.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/seq_divider_8.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, driving an external subtractor.
// Define SEQ_DIVIDER_INTERNAL_SUB_EN to compute the trial subtraction internally instead.
module seq_divider_8 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_w_clk,
  input  logic             i_w_reset,
  input  logic             i_w_start,
  input  logic [WIDTH-1:0] i_w_dividend,
  input  logic [WIDTH-1:0] i_w_divisor,
  output logic             o_w_busy,
  output logic             o_w_done,
  output logic [WIDTH-1:0] o_w_quotient,
  output logic [WIDTH-1:0] o_w_remainder,
  output logic             o_w_div_by_zero,
  output logic [WIDTH-1:0] o_w_sub_a,
  output logic [WIDTH-1:0] o_w_sub_b,
  output logic             o_w_sub_borrow_in,
  input  logic [WIDTH-1:0] i_w_sub_diff,
  input  logic             i_w_sub_carry
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] r, q, d;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shifted, diff, r_next, q_next;
  logic             no_borrow;

  // R stays below 2^(WIDTH-1) before every shift, so the shifted value fits WIDTH bits.
  assign shifted = {r[WIDTH-2:0], q[WIDTH-1]};

`ifdef SEQ_DIVIDER_INTERNAL_SUB_EN
  logic unused_sub;
  assign unused_sub        = ^{i_w_sub_diff, i_w_sub_carry};
  assign diff              = shifted - d;
  assign no_borrow         = (shifted >= d);
  assign o_w_sub_a         = '0;
  assign o_w_sub_b         = '0;
`else
  assign diff              = i_w_sub_diff;
  assign no_borrow         = i_w_sub_carry;
  assign o_w_sub_a         = (state == RUN) ? shifted : '0;
  assign o_w_sub_b         = d;
`endif
  assign o_w_sub_borrow_in = 1'b0;

  assign r_next   = no_borrow ? diff : shifted;
  assign q_next   = {q[WIDTH-2:0], no_borrow};
  assign o_w_busy = (state != IDLE);
  assign o_w_done = (state == DONE);

  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_w_start) state_next = (i_w_divisor != '0) ? RUN : DONE;
      RUN:     if (cnt == CW'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      r               <= '0;
      q               <= '0;
      d               <= '0;
      cnt             <= '0;
      o_w_quotient    <= '0;
      o_w_remainder   <= '0;
      o_w_div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_w_start) begin
            d <= i_w_divisor;
            if (i_w_divisor != '0) begin
              r   <= '0;
              q   <= i_w_dividend;
              cnt <= CW'(WIDTH);
            end else begin
              o_w_quotient    <= '1;
              o_w_remainder   <= i_w_dividend;
              o_w_div_by_zero <= 1'b1;
            end
          end
        end
        RUN: begin
          r   <= r_next;
          q   <= q_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            o_w_quotient    <= q_next;
            o_w_remainder   <= r_next;
            o_w_div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_8.sv
// Directed self-checking bench for seq_divider_8 with a behavioural model of the external subtractor.
module tb_seq_divider_8;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] dividend, divisor, quotient, remainder, sub_a, sub_b, sub_diff;
  logic       busy, done, dz, sub_bin, sub_carry;
  logic [8:0] sub_full;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  seq_divider_8 #(.WIDTH(8)) dut (
    .i_w_clk           (clk),
    .i_w_reset         (rst),
    .i_w_start         (start),
    .i_w_dividend      (dividend),
    .i_w_divisor       (divisor),
    .o_w_busy          (busy),
    .o_w_done          (done),
    .o_w_quotient      (quotient),
    .o_w_remainder     (remainder),
    .o_w_div_by_zero   (dz),
    .o_w_sub_a         (sub_a),
    .o_w_sub_b         (sub_b),
    .o_w_sub_borrow_in (sub_bin),
    .i_w_sub_diff      (sub_diff),
    .i_w_sub_carry     (sub_carry)
  );

  // Ripple subtractor stand-in: A - B - borrow_in, carry high when no borrow.
  always_comb begin
    sub_full  = {1'b0, sub_a} - {1'b0, sub_b} - {8'd0, sub_bin};
    sub_diff  = sub_full[7:0];
    sub_carry = ~sub_full[8];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One operation: start at the next edge, optionally poke a stray start in RUN cycle
  // poke_k or hold start high (with new operands) through the end of the operation.
  task automatic do_op(input string tag, input logic [7:0] dd, input logic [7:0] dv,
                       input logic [7:0] eq, input logic [7:0] er, input logic edz,
                       input int elat, input int poke_k, input bit hold, input int exp_a3);
    int lat, busy_n;
    @(negedge clk);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(posedge clk);
    #1;
    if (hold) begin
      dividend = 8'd50;
      divisor  = 8'd5;
    end else begin
      start = 1'b0;
    end
    lat    = 0;
    busy_n = 0;
    for (int k = 1; k <= 20; k++) begin
      if (poke_k != 0 && k == poke_k + 1) start = 1'b0;
      if (poke_k != 0 && k == poke_k) begin
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
      end
      if (exp_a3 >= 0 && k == 3) begin
`ifdef SEQ_DIVIDER_INTERNAL_SUB_EN
        check({tag, "_sub_a"}, 32'(sub_a), 32'd0);
        check({tag, "_sub_b"}, 32'(sub_b), 32'd0);
`else
        check({tag, "_sub_a"}, 32'(sub_a), exp_a3);
        check({tag, "_sub_b"}, 32'(sub_b), 32'(dv));
`endif
        check({tag, "_sub_bin"}, 32'(sub_bin), 32'd0);
      end
      if (busy) busy_n++;
      if (done) begin
        lat = k;
        break;
      end
      @(posedge clk);
      #1;
    end
    check({tag, "_latency"}, lat, elat);
    check({tag, "_busy_cycles"}, busy_n, elat);
    check({tag, "_quotient"}, 32'(quotient), 32'(eq));
    check({tag, "_remainder"}, 32'(remainder), 32'(er));
    check({tag, "_dz"}, 32'(dz), 32'(edz));
    @(posedge clk);
    #1;
    check({tag, "_done_fall"}, 32'(done), 32'd0);
    check({tag, "_busy_fall"}, 32'(busy), 32'd0);
    check({tag, "_q_hold"}, 32'(quotient), 32'(eq));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dz", 32'(dz), 32'd0);
    check("rst_sub_a", 32'(sub_a), 32'd0);
    check("rst_sub_b", 32'(sub_b), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op("d100_7",   8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 9, 0, 1'b0, 3);
    do_op("d255_1",   8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 9, 0, 1'b0, -1);
    do_op("d200_250", 8'd200, 8'd250, 8'd0,   8'd200, 1'b0, 9, 0, 1'b0, -1);
    do_op("d55_0",    8'd55,  8'd0,   8'd255, 8'd55,  1'b1, 1, 0, 1'b0, -1);
    do_op("d9_3",     8'd9,   8'd3,   8'd3,   8'd0,   1'b0, 9, 0, 1'b0, -1);
    do_op("poke_run", 8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 9, 3, 1'b0, -1);
    do_op("hold",     8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 9, 0, 1'b1, -1);
    do_op("d50_5",    8'd50,  8'd5,   8'd10,  8'd0,   1'b0, 9, 0, 1'b0, -1);

    // Abort mid-run with an asynchronous reset between clock edges.
    @(negedge clk);
    dividend = 8'd255;
    divisor  = 8'd16;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy_before", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    check("abort_dz", 32'(dz), 32'd0);
    check("abort_sub_a", 32'(sub_a), 32'd0);
    check("abort_sub_b", 32'(sub_b), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_idle_done", 32'(done), 32'd0);
    check("abort_idle_busy", 32'(busy), 32'd0);

    do_op("d255_16", 8'd255, 8'd16, 8'd15, 8'd15, 1'b0, 9, 0, 1'b0, -1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
